// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Optional divider datapath is built only when MIPS_MD_DIV_EN is defined.
module mips_muldiv #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        md__start,
  input  logic [1:0]  md__op,
  input  logic [31:0] md__op1,
  input  logic [31:0] md__op2,
  input  logic        md__hi_we,
  input  logic        md__lo_we,
  input  logic [31:0] md__wdata,
  output logic        md__busy,
  output logic        md__done,
  output logic [31:0] md__hi,
  output logic [31:0] md__lo
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          q_neg_q, q_neg_d;      // sign of product or quotient
  logic [31:0]   acc_q, acc_d;          // product high half / partial remainder
  logic [31:0]   sh_q, sh_d;            // multiplier / dividend-then-quotient
  logic [31:0]   opnd_q, opnd_d;        // |multiplicand| / |divisor|
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          op_signed;
  logic          neg1, neg2;
  logic [31:0]   abs1, abs2;
  logic          last_step;

  logic [32:0]   mul_sum;
  logic [31:0]   mul_acc, mul_sh;
  logic [63:0]   mul_prod, mul_res;

`ifdef MIPS_MD_DIV_EN
  logic          r_neg_q, r_neg_d;      // remainder takes the dividend's sign
  logic          dz_q, dz_d;
  logic [32:0]   div_part;
  logic [33:0]   div_diff;
  logic          div_ok;
  logic [31:0]   div_acc, div_sh;
  logic [31:0]   div_quo, div_rem;
`endif

  assign op_signed = (md__op == OP_MULT) || (md__op == OP_DIV);
  assign neg1      = op_signed & md__op1[31];
  assign neg2      = op_signed & md__op2[31];
  assign abs1      = neg1 ? -md__op1 : md__op1;
  assign abs2      = neg2 ? -md__op2 : md__op2;
  assign last_step = (cnt_q == CW'(MD_CYCLES - 1));

  // Shift-add: the LSB of sh_q selects the add, the sum carry shifts back in.
  assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_acc  = mul_sum[32:1];
  assign mul_sh   = {mul_sum[0], sh_q[31:1]};
  assign mul_prod = {mul_acc, mul_sh};
  assign mul_res  = q_neg_q ? -mul_prod : mul_prod;

`ifdef MIPS_MD_DIV_EN
  // Restoring step: shift next dividend bit in, keep the difference if non-negative.
  assign div_part = {acc_q, sh_q[31]};
  assign div_diff = {1'b0, div_part} - {2'b00, opnd_q};
  assign div_ok   = ~div_diff[33];
  assign div_acc  = div_ok ? div_diff[31:0] : div_part[31:0];
  assign div_sh   = {sh_q[30:0], div_ok};
  assign div_quo  = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? -div_sh : div_sh);
  assign div_rem  = r_neg_q ? -div_acc : div_acc;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MIPS_MD_DIV_EN
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
`endif

    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
`ifdef MIPS_MD_DIV_EN
          acc_d = div_acc;
          sh_d  = div_sh;
          if (last_step) begin
            hi_d    = div_rem;
            lo_d    = div_quo;
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end else begin
          acc_d = mul_acc;
          sh_d  = mul_sh;
          if (last_step) begin
            hi_d    = mul_res[63:32];
            lo_d    = mul_res[31:0];
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (md__hi_we) hi_d = md__wdata;
        if (md__lo_we) lo_d = md__wdata;
        if (md__start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          is_div_d = md__op[1];
          q_neg_d  = neg1 ^ neg2;
          acc_d    = '0;
          sh_d     = md__op[1] ? abs1 : abs2;
          opnd_d   = md__op[1] ? abs2 : abs1;
`ifdef MIPS_MD_DIV_EN
          r_neg_d  = neg1;
          dz_d     = (md__op2 == 32'd0);
`endif
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MIPS_MD_DIV_EN
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MIPS_MD_DIV_EN
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign md__busy = (state_q == ST_RUN);
  assign md__done = (state_q == ST_DONE);
  assign md__hi   = hi_q;
  assign md__lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: the driver queues expected HI/LO and done cycle,
// a negedge monitor pops and compares on every md__done pulse.
module tb_mips_muldiv;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        md__start = 1'b0;
  logic [1:0]  md__op = 2'd0;
  logic [31:0] md__op1 = '0;
  logic [31:0] md__op2 = '0;
  logic        md__hi_we = 1'b0;
  logic        md__lo_we = 1'b0;
  logic [31:0] md__wdata = '0;
  logic        md__busy;
  logic        md__done;
  logic [31:0] md__hi;
  logic [31:0] md__lo;

  mips_muldiv #(.MD_CYCLES(32)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .md__start (md__start),
    .md__op    (md__op),
    .md__op1   (md__op1),
    .md__op2   (md__op2),
    .md__hi_we (md__hi_we),
    .md__lo_we (md__lo_we),
    .md__wdata (md__wdata),
    .md__busy  (md__busy),
    .md__done  (md__done),
    .md__hi    (md__hi),
    .md__lo    (md__lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (md__done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.at));
        check("result_hi", {32'd0, md__hi}, {32'd0, e.hi});
        check("result_lo", {32'd0, md__lo}, {32'd0, e.lo});
        check("busy_at_done", {63'd0, md__busy}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat);
    md__start = 1'b1;
    md__op    = op;
    md__op1   = a;
    md__op2   = b;
    sb.push_back('{eh, el, cyc + 1 + lat});
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    md__start = 1'b0;
    md__hi_we = 1'b0;
    md__lo_we = 1'b0;
    check("busy_after_issue", {63'd0, md__busy}, 64'd1);
  endtask

  task automatic issue_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el);
`ifdef MIPS_MD_DIV_EN
    issue(op, a, b, eh, el, 32);
`else
    issue(op, a, b, m_hi, m_lo, 1);
`endif
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (md__done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 100 cycles at cycle %0d", cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, md__busy}, 64'd0);
    check("reset_done", {63'd0, md__done}, 64'd0);
    check("reset_hi", {32'd0, md__hi}, 64'd0);
    check("reset_lo", {32'd0, md__lo}, 64'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Max unsigned product, then back-to-back signed multiply issued in the DONE cycle.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32);
    wait_done();
    issue(OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32);
    repeat (3) @(negedge clk);
    md__start = 1'b1;
    md__op    = OP_MULTU;
    md__op1   = 32'd2;
    md__op2   = 32'd2;
    md__lo_we = 1'b1;
    md__wdata = 32'h0000_1234;
    @(negedge clk);
    md__start = 1'b0;
    md__lo_we = 1'b0;
    check("mtlo_busy_lo", {32'd0, md__lo}, 64'h0000_0001);
    check("start_busy_hi", {32'd0, md__hi}, 64'hFFFF_FFFE);
    check("start_busy_still_busy", {63'd0, md__busy}, 64'd1);
    wait_done();
    @(negedge clk);

    // MTHI/MTLO while idle.
    md__hi_we = 1'b1;
    md__wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    md__hi_we = 1'b0;
    check("mthi_idle_hi", {32'd0, md__hi}, 64'hDEAD_BEEF);
    check("mthi_idle_lo", {32'd0, md__lo}, 64'hFFFF_FFEB);
    md__lo_we = 1'b1;
    md__wdata = 32'h0BAD_F00D;
    @(negedge clk);
    md__lo_we = 1'b0;
    check("mtlo_idle_lo", {32'd0, md__lo}, 64'h0BAD_F00D);

    // MTHI in the same cycle as an accepted start: lands, then the result overwrites it.
    md__hi_we = 1'b1;
    md__wdata = 32'hAAAA_5555;
    issue(OP_MULTU, 32'd5, 32'd7, 32'd0, 32'd35, 32);
    check("mthi_with_start_hi", {32'd0, md__hi}, 64'hAAAA_5555);
    wait_done();
    issue(OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 32);
    wait_done();
    issue(OP_MULTU, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 32);
    wait_done();

    // Divides; without the divider these finish at E1 with HI/LO untouched.
    issue_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done();
    issue_div(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    wait_done();
    issue_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    wait_done();
    issue_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    wait_done();
    issue_div(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    wait_done();
    issue_div(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);
    wait_done();
    @(negedge clk);

    // Reset asserted mid-multiply aborts with no done pulse.
    md__start = 1'b1;
    md__op    = OP_MULT;
    md__op1   = 32'd12345;
    md__op2   = 32'hFFFF_FFFD;
    @(negedge clk);
    md__start = 1'b0;
    repeat (9) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("abort_busy", {63'd0, md__busy}, 64'd0);
    check("abort_done", {63'd0, md__done}, 64'd0);
    check("abort_hi", {32'd0, md__hi}, 64'd0);
    check("abort_lo", {32'd0, md__lo}, 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    check("after_abort_busy", {63'd0, md__busy}, 64'd0);
    check("after_abort_hi", {32'd0, md__hi}, 64'd0);

    issue(OP_MULT, 32'd12345, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_6F55, 32);
    wait_done();
    @(negedge clk);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
